// File: rtl/nios2_timer_mem_pkg.sv
// Shared definitions for the sys_mem arbiter slice.
// Holds the default geometry of the shared RAM port and the state
// encoding of the top-level clear/serve FSM.
package nios2_timer_mem_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W_DEF   = 4;
  localparam int DEPTH_DEF  = 10000;

  // CLEAR: zero-fill engine owns the memory port.
  // SERVE: requesters share the port through the round-robin arbiter.
  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;

endpackage

// File: rtl/nios2_timer_rr_arbiter.sv
// Round-robin grant generator.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   req_i         - active requests (one bit per master)
//   accept_i      - the current grant is consumed this cycle
//   grant_o       - one-hot grant, combinational from req_i and last_grant
//   grant_any_o   - some requester is granted
// The search starts one past the last accepted requester, so the most
// recently served master has the lowest priority. last_grant resets to
// NUM_REQ-1 so that requester 0 wins the first contest.
module nios2_timer_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               accept_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               grant_any_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] sel_idx;
  int               idx;

  always_comb begin
    grant_o     = '0;
    grant_any_o = 1'b0;
    sel_idx     = last_q;
    idx         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any_o && req_i[idx]) begin
        grant_any_o  = 1'b1;
        grant_o[idx] = 1'b1;
        sel_idx      = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= IDX_W'(NUM_REQ - 1);
    end else if (accept_i && grant_any_o) begin
      last_q <= sel_idx;
    end
  end

endmodule

// File: rtl/nios2_timer_mem_arbiter.sv
// Shares one Avalon-MM port of the dual-port sys_mem between NUM_REQ masters.
// After reset an optional zero-fill engine writes 0 to words 0..DEPTH-1,
// then the block serves one single-word transfer per cycle with round-robin
// arbitration. Memory read latency is one cycle; readdatavalid is steered
// back to the master that issued the read.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   req_address/read/write/
//   writedata/byteenable            - packed per-requester Avalon inputs
//   req_waitrequest                 - low only for the granted requester
//   req_readdata                    - shared, straight from mem_readdata
//   req_readdatavalid               - one-hot, one cycle after the read
//   mem_*                           - memory-side Avalon master
//   init_done                       - high while serving
// Handshake: a transfer on requester i happens in a cycle where
// (req_read[i] | req_write[i]) is high and req_waitrequest[i] is low.
// Write wins when read and write are both high. All outputs are held at
// their reset values while reset is high, which also suppresses a
// readdatavalid still in flight from the cycle before reset.
module nios2_timer_mem_arbiter
  import nios2_timer_mem_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int BE_W           = BE_W_DEF,
  parameter int DEPTH          = DEPTH_DEF,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  input  logic [NUM_REQ*BE_W-1:0]   req_byteenable,
  output logic [NUM_REQ-1:0]        req_waitrequest,
  output logic [DATA_W-1:0]         req_readdata,
  output logic [NUM_REQ-1:0]        req_readdatavalid,
  output logic                      mem_chipselect,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [BE_W-1:0]           mem_byteenable,
  output logic [DATA_W-1:0]         mem_writedata,
  input  logic [DATA_W-1:0]         mem_readdata,
  output logic                      init_done
);

  localparam state_t START_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : SERVE;

  state_t              state_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic [NUM_REQ-1:0]  rvalid_q;   // owner of the read answered next cycle
  logic [NUM_REQ-1:0]  rd_accept;
  logic [NUM_REQ-1:0]  arb_req;
  logic [NUM_REQ-1:0]  grant;
  logic                grant_any;
  logic                serving;

  assign serving = (state_q == SERVE) && !reset;
  assign arb_req = (req_read | req_write) & {NUM_REQ{serving}};

  nios2_timer_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk         (clk),
    .reset       (reset),
    .req_i       (arb_req),
    .accept_i    (grant_any),
    .grant_o     (grant),
    .grant_any_o (grant_any)
  );

  always_comb begin
    req_waitrequest = '1;
    rd_accept       = '0;
    mem_chipselect  = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_byteenable  = '0;
    mem_writedata   = '0;
    if (!reset && state_q == CLEAR) begin
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
      mem_address    = clr_cnt_q;
      mem_byteenable = '1;
    end else if (serving) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          req_waitrequest[i] = 1'b0;
          rd_accept[i]       = req_read[i] && !req_write[i];
          mem_chipselect     = 1'b1;
          mem_write          = req_write[i];
          mem_address        = req_address[i*ADDR_W +: ADDR_W];
          mem_byteenable     = req_byteenable[i*BE_W +: BE_W];
          mem_writedata      = req_writedata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= START_STATE;
      clr_cnt_q <= '0;
      rvalid_q  <= '0;
    end else begin
      rvalid_q <= rd_accept;
      if (state_q == CLEAR) begin
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_q <= SERVE;
        end else begin
          clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
        end
      end
    end
  end

  assign req_readdata      = mem_readdata;
  assign req_readdatavalid = rvalid_q & {NUM_REQ{!reset}};
  assign init_done         = serving;

endmodule

// File: tb/tb_nios2_timer_mem_arbiter.sv
// Directed bench for nios2_timer_mem_arbiter with a behavioural 1-cycle RAM.
module tb_nios2_timer_mem_arbiter;

  localparam int N  = 2;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int DP = 10000;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N*AW-1:0] req_address;
  logic [N-1:0]    req_read;
  logic [N-1:0]    req_write;
  logic [N*DW-1:0] req_writedata;
  logic [N*BW-1:0] req_byteenable;
  logic [N-1:0]    req_waitrequest;
  logic [DW-1:0]   req_readdata;
  logic [N-1:0]    req_readdatavalid;
  logic            mem_chipselect;
  logic            mem_write;
  logic [AW-1:0]   mem_address;
  logic [BW-1:0]   mem_byteenable;
  logic [DW-1:0]   mem_writedata;
  logic [DW-1:0]   mem_readdata;
  logic            init_done;

  nios2_timer_mem_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .DEPTH(DP), .CLEAR_ON_RESET(1)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_address       (req_address),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_writedata     (req_writedata),
    .req_byteenable    (req_byteenable),
    .req_waitrequest   (req_waitrequest),
    .req_readdata      (req_readdata),
    .req_readdatavalid (req_readdatavalid),
    .mem_chipselect    (mem_chipselect),
    .mem_write         (mem_write),
    .mem_address       (mem_address),
    .mem_byteenable    (mem_byteenable),
    .mem_writedata     (mem_writedata),
    .mem_readdata      (mem_readdata),
    .init_done         (init_done)
  );

  // behavioural RAM, pre-filled with a non-zero pattern so the clear is visible
  logic [DW-1:0] ram [0:DP-1];
  logic [DW-1:0] rd_q;
  assign mem_readdata = rd_q;

  initial begin
    for (int i = 0; i < DP; i++) ram[i] = 32'hA5A5A5A5;
    rd_q = 32'hA5A5A5A5;
  end

  always @(posedge clk) begin
    if (mem_chipselect && int'(mem_address) < DP) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        rd_q <= ram[mem_address];
      end
    end
  end

  // scoreboard counters
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_address    = '0;
    req_read       = '0;
    req_write      = '0;
    req_writedata  = '0;
    req_byteenable = '0;
  endtask

  task automatic set_req(input int i, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] be);
    req_read[i]                 = rd;
    req_write[i]                = wr;
    req_address[i*AW +: AW]     = a;
    req_writedata[i*DW +: DW]   = d;
    req_byteenable[i*BW +: BW]  = be;
  endtask

  // Follows the clear from its first cycle; returns at the negedge of the
  // first cycle with init_done high (or after the cycle budget).
  task automatic run_clear(output int n, output int bad);
    n   = 0;
    bad = 0;
    for (int c = 0; c < DP + 100; c++) begin
      @(negedge clk);
      if (init_done) break;
      if (!(mem_chipselect && mem_write && mem_byteenable == 4'hF &&
            mem_writedata == 32'h0 && int'(mem_address) == n)) bad++;
      if (req_waitrequest != 2'b11) bad++;
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  int n_clr, bad_clr, cnt0, cnt1, guard;
  logic [N-1:0]  exp_rdv;
  logic [DW-1:0] exp_data;

  initial begin
    reset = 1'b1;
    clear_reqs();
    repeat (3) next_cycle();

    // reset values
    @(negedge clk);
    check("rst_waitreq", req_waitrequest, 2'b11);
    check("rst_rdv", req_readdatavalid, 2'b00);
    check("rst_cs", mem_chipselect, 1'b0);
    check("rst_wr", mem_write, 1'b0);
    check("rst_init_done", init_done, 1'b0);

    // 1: full clear while both masters try to read word 9999
    next_cycle();
    reset = 1'b0;
    set_req(0, 1'b1, 1'b0, 14'd9999, 32'h0, 4'hF);
    set_req(1, 1'b1, 1'b0, 14'd9999, 32'h0, 4'hF);
    run_clear(n_clr, bad_clr);
    check("t1_clear_writes", n_clr, DP);
    check("t1_clear_bad", bad_clr, 0);
    check("t1_init_done", init_done, 1'b1);
    check("t1_first_grant", req_waitrequest, 2'b10);
    next_cycle();
    clear_reqs();
    @(negedge clk);
    check("t1_rdv", req_readdatavalid, 2'b01);
    check("t1_rdata", req_readdata, 32'h0);

    // 2: write then read back on req0
    next_cycle();
    set_req(0, 1'b0, 1'b1, 14'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    check("t2_wr_waitreq", req_waitrequest, 2'b10);
    check("t2_mem_write", mem_write, 1'b1);
    check("t2_mem_addr", mem_address, 14'h10);
    next_cycle();
    clear_reqs();
    set_req(0, 1'b1, 1'b0, 14'h10, 32'h0, 4'hF);
    @(negedge clk);
    check("t2_rd_waitreq", req_waitrequest, 2'b10);
    check("t2_rdv_early", req_readdatavalid, 2'b00);
    next_cycle();
    clear_reqs();
    @(negedge clk);
    check("t2_rdv", req_readdatavalid, 2'b01);
    check("t2_rdata", req_readdata, 32'hDEADBEEF);

    // 3: partial write from req1, read back from req0
    next_cycle();
    set_req(1, 1'b0, 1'b1, 14'h10, 32'h12345678, 4'h3);
    @(negedge clk);
    check("t3_waitreq", req_waitrequest, 2'b01);
    check("t3_mem_be", mem_byteenable, 4'h3);
    next_cycle();
    clear_reqs();
    set_req(0, 1'b1, 1'b0, 14'h10, 32'h0, 4'hF);
    next_cycle();
    clear_reqs();
    @(negedge clk);
    check("t3_rdv", req_readdatavalid, 2'b01);
    check("t3_rdata", req_readdata, 32'hDEAD5678);

    // read+write together is a write; out-of-range address passes through
    next_cycle();
    set_req(1, 1'b1, 1'b1, 14'h3FFF, 32'h0BADF00D, 4'hF);
    @(negedge clk);
    check("rw_is_write", mem_write, 1'b1);
    check("rw_addr_pass", mem_address, 14'h3FFF);
    next_cycle();
    clear_reqs();
    @(negedge clk);
    check("rw_no_rdv", req_readdatavalid, 2'b00);

    // 5: req1 alone, then both -> req0 first
    next_cycle();
    set_req(1, 1'b0, 1'b1, 14'h20, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    check("t5_req1_alone", req_waitrequest, 2'b01);
    next_cycle();
    clear_reqs();
    set_req(0, 1'b1, 1'b0, 14'h10, 32'h0, 4'hF);
    set_req(1, 1'b1, 1'b0, 14'h20, 32'h0, 4'hF);

    // 4: continuous reads from both, alternating grants 0,1,0,1...
    cnt0 = 0;
    cnt1 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("t4_grant_%0d", k), req_waitrequest, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k == 0) begin
        exp_rdv = 2'b00;
      end else begin
        exp_rdv  = ((k - 1) % 2 == 0) ? 2'b01 : 2'b10;
        exp_data = ((k - 1) % 2 == 0) ? 32'hDEAD5678 : 32'hCAFEF00D;
        check($sformatf("t4_rdata_%0d", k), req_readdata, exp_data);
      end
      check($sformatf("t4_rdv_%0d", k), req_readdatavalid, exp_rdv);
      cnt0 += int'(req_readdatavalid[0]);
      cnt1 += int'(req_readdatavalid[1]);
      next_cycle();
      if (k == 7) clear_reqs();
    end
    @(negedge clk);
    check("t4_rdv_last", req_readdatavalid, 2'b10);
    check("t4_rdata_last", req_readdata, 32'hCAFEF00D);
    cnt0 += int'(req_readdatavalid[0]);
    cnt1 += int'(req_readdatavalid[1]);
    check("t4_count0", cnt0, 4);
    check("t4_count1", cnt1, 4);

    // 7: reset in the cycle after an accepted read
    next_cycle();
    set_req(0, 1'b1, 1'b0, 14'h10, 32'h0, 4'hF);
    @(negedge clk);
    check("t7_rd_accept", req_waitrequest, 2'b10);
    next_cycle();
    reset = 1'b1;
    clear_reqs();
    @(negedge clk);
    check("t7_rdv", req_readdatavalid, 2'b00);
    check("t7_waitreq", req_waitrequest, 2'b11);
    check("t7_cs", mem_chipselect, 1'b0);
    check("t7_wr", mem_write, 1'b0);
    check("t7_init_done", init_done, 1'b0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("t7_rdv_after", req_readdatavalid, 2'b00);
    check("t7_clear_addr0", mem_address, 14'd0);

    // 6: reset while the clear is at address 500 -> restart from 0
    guard = 0;
    while (int'(mem_address) != 500 && guard < 1000) begin
      next_cycle();
      @(negedge clk);
      guard++;
    end
    check("t6_reach500", mem_address, 14'd500);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_cs", mem_chipselect, 1'b0);
    next_cycle();
    reset = 1'b0;
    run_clear(n_clr, bad_clr);
    check("t6_clear_writes", n_clr, DP);
    check("t6_clear_bad", bad_clr, 0);
    check("t6_init_done", init_done, 1'b1);
    next_cycle();
    set_req(0, 1'b1, 1'b0, 14'h10, 32'h0, 4'hF);
    next_cycle();
    clear_reqs();
    @(negedge clk);
    check("t6_rdv", req_readdatavalid, 2'b01);
    check("t6_rdata_zero", req_readdata, 32'h0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
